// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: EX redirects, ID JAL targets, optional BTB prediction, PC+4.
// Define IF_PC_GEN_BTB_EN to build the direct-mapped branch target buffer.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] PCF,
  output logic        pred_taken_f,
  input  logic        jal_d,
  input  logic [31:0] jal_target_d,
  input  logic        ex_en,
  input  logic        ex_br,
  input  logic        ex_jalr,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        redirect_e
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [31:0] pc_plus4;
  logic [31:0] ex_pc_plus4;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;

  assign pc_plus4    = PCF + 32'd4;
  assign ex_pc_plus4 = ex_pc + 32'd4;

  // A JALR always redirects; a branch takes its fall-through path when it was predicted but not taken.
  assign redirect_target = (ex_jalr || ex_taken) ? ex_target : ex_pc_plus4;

`ifdef IF_PC_GEN_BTB_EN
  logic             btb_valid  [BTB_ENTRIES];
  logic [1:0]       btb_cnt    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [29:0]      btb_target [BTB_ENTRIES];

  logic [IDX-1:0]   idx_f;
  logic [IDX-1:0]   idx_e;
  logic             hit_f;
  logic             hit_e;
  logic             train;
  logic [31:0]      btb_pred_target;

  assign idx_f = PCF[IDX+1:2];
  assign idx_e = ex_pc[IDX+1:2];
  assign hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == PCF[31:IDX+2]);
  assign hit_e = btb_valid[idx_e] && (btb_tag[idx_e] == ex_pc[31:IDX+2]);
  assign train = ex_en && ex_br;

  assign pred_taken_f    = hit_f && btb_cnt[idx_f][1];
  assign btb_pred_target = {btb_target[idx_f], 2'b00};
  assign redirect_e      = ex_jalr || (ex_br && (ex_taken != ex_pred_taken));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // this is also what makes a same-cycle lookup see the old BTB contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= 2'b00;
      end
    end else if (train) begin
      if (hit_e) begin
        if (ex_taken && btb_cnt[idx_e] != 2'b11)
          btb_cnt[idx_e] <= btb_cnt[idx_e] + 2'd1;
        else if (!ex_taken && btb_cnt[idx_e] != 2'b00)
          btb_cnt[idx_e] <= btb_cnt[idx_e] - 2'd1;
      end else if (ex_taken) begin
        btb_valid[idx_e] <= 1'b1;
        btb_cnt[idx_e]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target storage has no reset; it is never consulted while valid is clear.
  always_ff @(posedge clk) begin
    if (train && ex_taken) begin
      btb_tag[idx_e]    <= ex_pc[31:IDX+2];
      btb_target[idx_e] <= ex_target[31:2];
    end
  end
`else
  logic unused_ok;

  assign unused_ok    = ex_en ^ ex_pred_taken;
  assign pred_taken_f = 1'b0;
  assign redirect_e   = ex_jalr || (ex_br && ex_taken);
`endif

  // NOTE: next_pc is defaulted first so every path assigns it and no latch is inferred.
  always_comb begin
    next_pc = PCF;
    if (redirect_e)
      next_pc = redirect_target;
    else if (jal_d && en)
      next_pc = jal_target_d;
`ifdef IF_PC_GEN_BTB_EN
    else if (en && pred_taken_f)
      next_pc = btb_pred_target;
`endif
    else if (en)
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      PCF <= RESET_PC;
    else
      PCF <= next_pc & 32'hFFFF_FFFC;
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed, table-driven bench for if_pc_gen; BTB sequences run when IF_PC_GEN_BTB_EN is defined.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] PCF;
  logic        pred_taken_f;
  logic        jal_d;
  logic [31:0] jal_target_d;
  logic        ex_en;
  logic        ex_br;
  logic        ex_jalr;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        redirect_e;

  int total = 0;
  int bad   = 0;

  if_pc_gen #(.RESET_PC(32'h100), .BTB_ENTRIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .PCF(PCF), .pred_taken_f(pred_taken_f),
    .jal_d(jal_d), .jal_target_d(jal_target_d), .ex_en(ex_en), .ex_br(ex_br),
    .ex_jalr(ex_jalr), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .redirect_e(redirect_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        jal;
    logic [31:0] jal_tgt;
    logic        br;
    logic        jalr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        exp_red;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic e, input logic j, input logic [31:0] jt,
                              input logic b, input logic jr, input logic [31:0] p,
                              input logic t, input logic [31:0] tg,
                              input logic r, input logic [31:0] ep);
    vec_t v;
    v.en = e; v.jal = j; v.jal_tgt = jt; v.br = b; v.jalr = jr; v.pc = p;
    v.taken = t; v.tgt = tg; v.exp_red = r; v.exp_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    en = 0; jal_d = 0; jal_target_d = 0; ex_en = 0; ex_br = 0; ex_jalr = 0;
    ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pred_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch a PC via an ID-stage JAL, then leave inputs idle.
  task automatic goto_pc(input logic [31:0] pc);
    clr(); en = 1; jal_d = 1; jal_target_d = pc;
    tick();
    clr();
    #1;
  endtask

`ifdef IF_PC_GEN_BTB_EN
  // One EX-stage branch resolution with the fetch stage stalled.
  task automatic ex_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic pred, input logic exp_red, input logic [31:0] exp_pc,
                           input string name);
    clr(); ex_en = 1; ex_br = 1; ex_pc = pc; ex_taken = taken; ex_target = tgt;
    ex_pred_taken = pred;
    #1;
    check({name, "_redirect"}, 32'(redirect_e), 32'(exp_red));
    tick();
    check({name, "_pcf"}, PCF, exp_pc);
    clr();
    #1;
  endtask
`endif

  initial begin
    //             en jal jal_tgt        br jalr ex_pc          tk ex_tgt         red exp_pc
    vecs[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h104);
    vecs[1]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h108);
    vecs[2]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h10C);
    vecs[3]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h10C);
    vecs[4]  = mk(1, 1, 32'h402,        0, 0, 32'h0,          0, 32'h0,         0, 32'h400);
    vecs[5]  = mk(0, 1, 32'h500,        0, 0, 32'h0,          0, 32'h0,         0, 32'h400);
    vecs[6]  = mk(0, 0, 32'h0,          0, 1, 32'h0,          0, 32'h3,         1, 32'h0);
    vecs[7]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h4);
    vecs[8]  = mk(1, 1, 32'h400,        1, 0, 32'h1C0,        1, 32'h200,       1, 32'h200);
    vecs[9]  = mk(1, 0, 32'h0,          1, 0, 32'h80,         0, 32'h300,       0, 32'h204);
    vecs[10] = mk(1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          0, 32'h0,         0, 32'hFFFF_FFFC);
    vecs[11] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0);
    vecs[12] = mk(1, 1, 32'h300,        0, 1, 32'h0,          0, 32'h1000,      1, 32'h1000);
    vecs[13] = mk(1, 1, 32'h20,         0, 0, 32'h0,          0, 32'h0,         0, 32'h20);
    vecs[14] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h20);
    vecs[15] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h20);
    vecs[16] = mk(0, 0, 32'h0,          0, 1, 32'h0,          0, 32'h3,         1, 32'h0);

    // Reset, released mid-stall away from a clock edge.
    clr();
    rst_n = 0;
    #12;
    rst_n = 1;
    #1;
    check("rst_pcf", PCF, 32'h100);
    check("rst_pred", 32'(pred_taken_f), 32'h0);
    check("rst_redirect", 32'(redirect_e), 32'h0);
    tick();
    check("rst_stall_hold", PCF, 32'h100);

    for (int i = 0; i < 17; i++) begin
      clr();
      en = vecs[i].en; jal_d = vecs[i].jal; jal_target_d = vecs[i].jal_tgt;
      ex_br = vecs[i].br; ex_jalr = vecs[i].jalr; ex_pc = vecs[i].pc;
      ex_taken = vecs[i].taken; ex_target = vecs[i].tgt;
      #1;
      check($sformatf("vec%0d_redirect", i), 32'(redirect_e), 32'(vecs[i].exp_red));
      check($sformatf("vec%0d_pred", i), 32'(pred_taken_f), 32'h0);
      tick();
      check($sformatf("vec%0d_pcf", i), PCF, vecs[i].exp_pc);
    end
    clr();

`ifdef IF_PC_GEN_BTB_EN
    // Training of the branch at 0x40 -> 0x80 and its counter.
    goto_pc(32'h40);
    check("btb_cold_pred", 32'(pred_taken_f), 32'h0);
    ex_branch(32'h40, 1, 32'h80, 0, 1, 32'h80, "train1");
    goto_pc(32'h40);
    check("btb_cnt2_pred", 32'(pred_taken_f), 32'h1);
    ex_branch(32'h40, 1, 32'h80, 1, 0, 32'h40, "train2");
    check("btb_cnt3_pred", 32'(pred_taken_f), 32'h1);
    en = 1;
    tick();
    check("btb_pred_target", PCF, 32'h80);
    ex_branch(32'h40, 0, 32'h80, 1, 1, 32'h44, "mispred1");
    goto_pc(32'h40);
    check("btb_cnt3to2_pred", 32'(pred_taken_f), 32'h1);
    ex_branch(32'h40, 0, 32'h80, 1, 1, 32'h44, "mispred2");
    goto_pc(32'h40);
    check("btb_cnt1_pred", 32'(pred_taken_f), 32'h0);

    // Fall-through target wraps modulo 2^32; ex_en=0 leaves the BTB untouched.
    clr(); ex_br = 1; ex_pc = 32'hFFFF_FFFC; ex_taken = 0; ex_pred_taken = 1;
    #1;
    check("wrap_redirect", 32'(redirect_e), 32'h1);
    tick();
    check("wrap_pcf", PCF, 32'h0);
    clr();

    // 0x40 and 0x60 share index 0: the later allocation replaces the earlier.
    ex_branch(32'h40, 1, 32'h80, 0, 1, 32'h80, "retrain40");
    ex_branch(32'h60, 1, 32'h90, 0, 1, 32'h90, "alloc60");
    goto_pc(32'h40);
    check("btb_replaced_pred", 32'(pred_taken_f), 32'h0);
    goto_pc(32'h60);
    check("btb_new_pred", 32'(pred_taken_f), 32'h1);
`else
    goto_pc(32'h60);
`endif

    // Asynchronous reset mid-cycle, away from the clock edge.
    #2;
    rst_n = 0;
    #1;
    check("async_rst_pcf", PCF, 32'h100);
    check("async_rst_pred", 32'(pred_taken_f), 32'h0);
    #2;
    rst_n = 1;
    goto_pc(32'h60);
    check("post_rst_pcf", PCF, 32'h60);
    check("post_rst_pred", 32'(pred_taken_f), 32'h0);
    en = 1;
    tick();
    check("post_rst_seq", PCF, 32'h64);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
